// File: rtl/frame_config_ctrl.sv
// Configuration-frame sequencer: decodes sync/command/data words and strobes one latch row.
// Optional FRAME_PARITY_EN: command bit 16 must match the XOR of the following data word.
module frame_config_ctrl #(
  parameter int unsigned FRAME_BITS    = 32,
  parameter int unsigned MAX_FRAMES    = 20,
  parameter int unsigned STROBE_CYCLES = 2,
  parameter logic [31:0] SYNC_WORD     = 32'hFAB0_FAB1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [31:0]           s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [FRAME_BITS-1:0] FrameData,
  output logic [MAX_FRAMES-1:0] FrameStrobe,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned CntW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(STROBE_CYCLES - 1);
  localparam logic [7:0] OpWrite = 8'h01;
  localparam logic [7:0] OpEnd   = 8'h02;

  typedef enum logic [2:0] {
    StHunt, StCmd, StData, StDrop, StSetup, StStrobe, StHold, StDone
  } state_e;

  state_e                state_q, state_d;
  logic [7:0]            idx_q, idx_d;
  logic [FRAME_BITS-1:0] data_q, data_d;
  logic [MAX_FRAMES-1:0] strobe_q, strobe_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  par_q, par_d;
  logic                  accept, xfer, is_sync, idx_ok, parity_ok;
  logic                  unused_bits;

  assign unused_bits = ^s_data[23:8];
  assign is_sync     = (s_data == SYNC_WORD);
  assign idx_ok      = ({24'd0, s_data[7:0]} < MAX_FRAMES);

`ifdef FRAME_PARITY_EN
  assign parity_ok = ((^s_data) == par_q);
`else
  assign parity_ok = 1'b1;
`endif

  always_comb begin
    accept = 1'b0;
    unique case (state_q)
      StHunt, StCmd, StData, StDrop, StDone: accept = 1'b1;
      default:                               accept = 1'b0;
    endcase
  end

  assign xfer = s_valid & accept;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    err_d   = err_q;
    par_d   = par_q;
    case (state_q)
      StHunt, StDone: begin
        if (xfer && is_sync) begin
          done_d  = 1'b0;
          err_d   = 1'b0;
          state_d = StCmd;
        end
      end
      StCmd: begin
        if (xfer && !is_sync) begin
          if (s_data[31:24] == OpWrite) begin
            if (idx_ok) begin
              idx_d   = s_data[7:0];
              par_d   = s_data[16];
              state_d = StData;
            end else begin
              err_d   = 1'b1;
              state_d = StDrop;
            end
          end else if (s_data[31:24] == OpEnd) begin
            done_d  = 1'b1;
            state_d = StDone;
          end else begin
            err_d   = 1'b1;
            state_d = StHunt;
          end
        end
      end
      StData: begin
        if (xfer) begin
          if (parity_ok) begin
            data_d  = s_data[FRAME_BITS-1:0];
            state_d = StSetup;
          end else begin
            err_d   = 1'b1;
            state_d = StHunt;
          end
        end
      end
      StDrop: begin
        if (xfer) state_d = StHunt;
      end
      StSetup: begin
        cnt_d   = '0;
        state_d = StStrobe;
      end
      StStrobe: begin
        if (cnt_q == CntMax) state_d = StHold;
        else                 cnt_d   = cnt_q + 1'b1;
      end
      StHold:  state_d = StCmd;
      default: state_d = StHunt;
    endcase
  end

  // Strobe is registered from the next state so the latch enable is glitch-free.
  always_comb begin
    strobe_d = '0;
    if (state_d == StStrobe) strobe_d = MAX_FRAMES'(1) << idx_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= StHunt;
      idx_q    <= '0;
      data_q   <= '0;
      strobe_q <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      par_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      strobe_q <= strobe_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      par_q    <= par_d;
    end
  end

  assign s_ready     = accept & ~RST;
  assign busy        = (state_q != StHunt) && (state_q != StDone);
  assign FrameData   = data_q;
  assign FrameStrobe = strobe_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: doc/frame_config_ctrl.md
# frame_config_ctrl

Sequences configuration of the fabric's latch-based configuration memory. It accepts a 32-bit word stream over a valid/ready handshake and decodes sync, command and data words. For each frame written, it drives a stable frame data bus and pulses exactly one frame strobe, which is the latch-enable of one row of configuration latches. It sits between the bitstream source (UART/SPI/host bridge) and the tile frame-strobe/frame-data distribution.

## Interface
- FRAME_BITS, 32: width of FrameData; must be ≤ 32.
- MAX_FRAMES, 20: number of frame strobes; valid frame indices 0..MAX_FRAMES-1.
- STROBE_CYCLES, 2: strobe high time in cycles; must be ≥ 1.
- SYNC_WORD, 32'hFAB0_FAB1: stream synchronisation word.

Ports:
- CLK  in  1  single clock; all logic rising-edge.
- RST  in  1  reset; synchronous, active-high.
- s_data  in  32  stream word.
- s_valid  in  1  s_data valid.
- s_ready  out  1  controller accepts a word this cycle; transfer occurs when s_valid & s_ready.
- FrameData  out  FRAME_BITS  data presented to configuration latches D inputs.
- FrameStrobe  out  MAX_FRAMES  one-hot latch enable; at most one bit high.
- busy  out  1  high in any state other than HUNT and DONE.
- done  out  1  level; set on END command.
- err  out  1  sticky protocol error.

## Operation
- Command word fields:
  - [31:24] opcode: 0x01 = WRITE, 0x02 = END; any other value is illegal.
  - [16] parity bit (see Configuration).
  - [7:0] frame index.
- States:
  - HUNT: s_ready=1. Non-sync words are consumed and dropped. A sync word clears done and err, then → CMD.
  - CMD: s_ready=1.
    - A sync word stays in CMD (re-sync).
    - WRITE with index < MAX_FRAMES: latch the index → DATA.
    - WRITE with index ≥ MAX_FRAMES: set err → DROP.
    - END: set done → DONE.
    - Illegal opcode: set err → HUNT.
  - DATA: s_ready=1. Accept one word; FrameData ← s_data[FRAME_BITS-1:0] → SETUP. The next word is never treated as a command.
  - DROP: s_ready=1. Accept and discard one word → HUNT.
  - SETUP: s_ready=0. FrameData stable, strobe low, one cycle → STROBE.
  - STROBE: s_ready=0. FrameStrobe[index]=1 for exactly STROBE_CYCLES cycles → HOLD.
  - HOLD: s_ready=0. Strobe low, FrameData unchanged, one cycle → CMD.
  - DONE: s_ready=1. Behaves as HUNT, except that only a sync word leaves the state (→ CMD, clearing done).
- FrameData changes only on a DATA-state transfer or on reset. Between frames it retains the last value.
- s_valid held low stalls any accepting state indefinitely with no side effects.

## Timing
- Reset values:
  - FrameData=0, FrameStrobe=0, busy=0, done=0, err=0.
  - s_ready=0 in the reset cycle, then 1 (HUNT).
- A data word transferred on edge t produces:
  - FrameData valid from t+1.
  - FrameStrobe high over cycles t+2 .. t+1+STROBE_CYCLES.
  - Low again at t+2+STROBE_CYCLES.
  - s_ready high again at t+3+STROBE_CYCLES.
- Throughput: one frame per 4+STROBE_CYCLES cycles with back-to-back input (cmd, data, setup, strobe×N, hold).
- RST mid-strobe: FrameStrobe drops in the cycle after the RST edge sample, and the state returns to HUNT. There is no glitch and no partial retry.
- err and done are never set in the same cycle.

## Configuration
- FRAME_PARITY_EN defined:
  - Command bit [16] must equal the XOR of all 32 bits of the following data word.
  - On mismatch, at DATA acceptance: err set, no SETUP/STROBE, FrameData unchanged → HUNT.
- FRAME_PARITY_EN undefined: bit [16] is ignored; there is no parity logic.

## Test plan
- Reset then stream {FAB0_FAB1, 0x01000003, 0xDEADBEEF}:
  - FrameData=0xDEADBEEF one cycle before FrameStrobe=20'h00008.
  - Strobe is high for exactly 2 cycles.
  - s_ready low for 4 cycles.
- Junk words 0x12345678 ×3 before sync: no strobe, err=0; after sync and {0x01000000, 0x1} → FrameStrobe[0] pulses.
- Command 0x01000014 (index 20) then 0xAAAAAAAA: err=1, no strobe, FrameData unchanged; the next sync clears err.
- END command 0x02000000: done=1, busy=0; a following WRITE word is dropped; sync clears done.
- RST asserted in the first STROBE cycle: FrameStrobe=0 and FrameData=0 from the next cycle; s_ready=1 after RST deasserts.
- FRAME_PARITY_EN:
  - Data 0x00000001 with cmd bit16=0 → err=1, no strobe.
  - Same data with bit16=1 → strobe pulses.
